// File: rtl/axis_rx_pkg.sv
// Shared types for the AXI-Stream receive buffer: input FSM states, the
// default-geometry storage entry layout and the pointer-width helper.
package axis_rx_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    IN_PACKET  = 2'd2
  } rx_state_t;

  localparam int RX_DATA_W = 64;
  localparam int RX_KEEP_W = RX_DATA_W / 8;
  localparam int RX_USER_W = 3;

  // Field order matches the packed word written into the FIFO memory.
  typedef struct packed {
    logic [RX_DATA_W-1:0] data;
    logic [RX_KEEP_W-1:0] keep;
    logic [RX_USER_W-1:0] user;
    logic                 last;
  } rx_entry_t;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/axis_rx_buffer_if.sv
// Stream-in and FWFT stream-out signal bundle of axis_rx_buffer.
// slave = receiver view, master = source/consumer view.
interface axis_rx_buffer_if #(
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 3
) ();
  logic [DATA_WIDTH-1:0]   TDATA;
  logic                    TVALID;
  logic                    TREADY;
  logic                    TLAST;
  logic [DATA_WIDTH/8-1:0] TKEEP;
  logic [USER_WIDTH-1:0]   TUSER;

  logic [DATA_WIDTH-1:0]   out_data;
  logic [DATA_WIDTH/8-1:0] out_keep;
  logic [USER_WIDTH-1:0]   out_user;
  logic                    out_last;
  logic                    out_valid;
  logic                    out_ready;

  modport slave (
    input  TDATA, TVALID, TLAST, TKEEP, TUSER, out_ready,
    output TREADY, out_data, out_keep, out_user, out_last, out_valid
  );

  modport master (
    output TDATA, TVALID, TLAST, TKEEP, TUSER, out_ready,
    input  TREADY, out_data, out_keep, out_user, out_last, out_valid
  );
endinterface

// File: rtl/axis_rx_fifo_mem.sv
// Register-array storage for the receive FIFO: one synchronous write port,
// one asynchronous read port. No reset; contents are qualified by level.
module axis_rx_fifo_mem #(
  parameter int WIDTH = 76,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             ACLK,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge ACLK) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axis_rx_buffer.sv
// AXI-Stream receiver with FWFT FIFO, backpressure and packet tracking.
// Define AXIS_RX_STORE_FWD_EN for store-and-forward release of packets.
module axis_rx_buffer
  import axis_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 16,
  parameter int USER_WIDTH = 3
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  axis_rx_buffer_if.slave        s,
  output logic [$clog2(DEPTH):0] level,
  output logic                   rx_busy
);

  localparam int AW = ptr_w(DEPTH);
  localparam int LW = AW + 1;
  localparam int KW = DATA_WIDTH / 8;
  localparam int EW = DATA_WIDTH + KW + USER_WIDTH + 1;

  rx_state_t      state, state_nxt;
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [LW-1:0]  level_q;
  logic           tready, out_valid, full, push, pop;
  logic [EW-1:0]  wr_data, rd_data;

  assign full   = (level_q == LW'(DEPTH));
  assign tready = (state != IDLE) && !full;
  assign push   = s.TVALID && tready;
  assign pop    = out_valid && s.out_ready;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      level_q <= level_q + LW'(1);
      else if (pop && !push) level_q <= level_q - LW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:       state_nxt = WAIT_FIRST;
      WAIT_FIRST: if (push && !s.TLAST) state_nxt = IN_PACKET;
      IN_PACKET:  if (push && s.TLAST)  state_nxt = WAIT_FIRST;
      default:    state_nxt = IDLE;
    endcase
  end

`ifdef AXIS_RX_STORE_FWD_EN
  logic [LW-1:0] pkt_count;
  logic          push_last, pop_last;

  assign push_last = push && s.TLAST;
  assign pop_last  = pop && s.out_last;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      pkt_count <= '0;
    end else if (push_last && !pop_last) begin
      pkt_count <= pkt_count + LW'(1);
    end else if (pop_last && !push_last) begin
      pkt_count <= pkt_count - LW'(1);
    end
  end

  // A full FIFO with no complete packet must drain cut-through or it deadlocks.
  assign out_valid = (pkt_count != '0) || full;
`else
  assign out_valid = (level_q != '0);
`endif

  assign wr_data = {s.TDATA, s.TKEEP, s.TUSER, s.TLAST};

  axis_rx_fifo_mem #(
    .WIDTH (EW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .ACLK    (ACLK),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  assign {s.out_data, s.out_keep, s.out_user, s.out_last} = rd_data;
  assign s.out_valid = out_valid;
  assign s.TREADY    = tready;
  assign level       = level_q;
  assign rx_busy     = (state == IN_PACKET);

endmodule

// File: tb/tb_axis_rx_buffer.sv
// Randomised and directed bench for axis_rx_buffer against a queue-based model.
module tb_axis_rx_buffer;
  import axis_rx_pkg::*;

  localparam int DW    = 64;
  localparam int DEPTH = 16;
  localparam int UW    = 3;
  localparam int LW    = 5;

  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  always #5 ACLK = ~ACLK;

  axis_rx_buffer_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) bus ();
  logic [LW-1:0] level;
  logic          rx_busy;

  axis_rx_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .USER_WIDTH(UW)) dut (
    .ACLK    (ACLK),
    .ARESET  (ARESET),
    .s       (bus),
    .level   (level),
    .rx_busy (rx_busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: contents as a queue, plus "just reset" and "packet open" flags.
  rx_entry_t q[$];
  bit        m_idle = 1'b1;
  bit        m_open = 1'b0;
  bit        m_ok   = 1'b0;
  int        pop_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_valid();
`ifdef AXIS_RX_STORE_FWD_EN
    int c = 0;
    foreach (q[i]) if (q[i].last) c++;
    return (c != 0) || (q.size() == DEPTH);
`else
    return q.size() != 0;
`endif
  endfunction

  always @(negedge ACLK) begin
    bit push, pop, v;
    rx_entry_t e;
    if (m_ok) begin
      v = exp_valid();
      chk("tready",    bus.TREADY,    64'(!m_idle && q.size() < DEPTH));
      chk("level",     level,         64'(q.size()));
      chk("rx_busy",   rx_busy,       64'(m_open));
      chk("out_valid", bus.out_valid, 64'(v));
      if (v) begin
        chk("out_data", bus.out_data, q[0].data);
        chk("out_keep", bus.out_keep, 64'(q[0].keep));
        chk("out_user", bus.out_user, 64'(q[0].user));
        chk("out_last", bus.out_last, 64'(q[0].last));
      end
    end
    if (ARESET) begin
      q.delete();
      m_idle = 1'b1;
      m_open = 1'b0;
      m_ok   = 1'b1;
    end else if (m_ok) begin
      push = bus.TVALID && !m_idle && (q.size() < DEPTH);
      pop  = exp_valid() && bus.out_ready;
      if (pop) begin
        void'(q.pop_front());
        pop_cnt++;
      end
      if (push) begin
        e.data = bus.TDATA;
        e.keep = bus.TKEEP;
        e.user = bus.TUSER;
        e.last = bus.TLAST;
        q.push_back(e);
        m_open = !bus.TLAST;
      end
      m_idle = 1'b0;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  task automatic drive(input logic [63:0] d, input logic [7:0] k, input logic [2:0] u, input logic l);
    bus.TDATA  = d;
    bus.TKEEP  = k;
    bus.TUSER  = u;
    bus.TLAST  = l;
    bus.TVALID = 1'b1;
  endtask

  // Holds the word until accepted; returns just after the accepting edge.
  task automatic push_word(input logic [63:0] d, input logic [7:0] k, input logic [2:0] u, input logic l);
    drive(d, k, u, l);
    for (int i = 0; i < 300; i++) begin
      @(negedge ACLK);
      if (bus.TREADY) begin
        @(posedge ACLK);
        #1;
        return;
      end
    end
    n_tests++;
    n_fail++;
    $display("FAIL push_timeout: TREADY stayed 0, required 1");
    bus.TVALID = 1'b0;
  endtask

  logic [63:0] lit [4];
  int          pop_base;
  bit          acc;

  initial begin
    lit[0] = 64'h11; lit[1] = 64'h22; lit[2] = 64'h33; lit[3] = 64'h44;
    bus.TDATA = '0; bus.TKEEP = '0; bus.TUSER = '0; bus.TLAST = 1'b0;
    bus.TVALID = 1'b0; bus.out_ready = 1'b0;
    ARESET = 1'b1;
    cyc(3);
    ARESET = 1'b0;

    // Reset, then idle
    @(negedge ACLK);
    chk("rst_tready_c1", bus.TREADY, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_rx_busy", rx_busy, 0);
    @(negedge ACLK);
    chk("rst_tready_c2", bus.TREADY, 1);
    @(posedge ACLK); #1;

    // 4-word packet, consumer always ready
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_word(lit[i], 8'hFF, 3'(i), i == 3);
      bus.TVALID = 1'b0;
      @(negedge ACLK);
      chk("pkt4_rx_busy", rx_busy, 64'(i < 3));
`ifdef AXIS_RX_STORE_FWD_EN
      chk("pkt4_sf_valid", bus.out_valid, 64'(i == 3));
`else
      chk("pkt4_valid", bus.out_valid, 1);
      chk("pkt4_data", bus.out_data, lit[i]);
      chk("pkt4_last", bus.out_last, 64'(i == 3));
`endif
      @(posedge ACLK); #1;
    end
    cyc(6);
    chk("pkt4_drained", level, 0);

    // Fill to DEPTH with a 17-word packet, hold, single pop
    bus.out_ready = 1'b0;
    for (int i = 0; i < 16; i++)
      push_word({$urandom, $urandom}, 8'($urandom), 3'($urandom), 1'b0);
    drive(64'hF00D_0017, 8'h0F, 3'd4, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      chk("full_tready", bus.TREADY, 0);
      chk("full_level", level, 16);
    end
    @(posedge ACLK); #1;
    bus.out_ready = 1'b1;
    @(posedge ACLK); #1;
    bus.out_ready = 1'b0;
    @(negedge ACLK);
    chk("after_pop_level", level, 15);
    chk("after_pop_tready", bus.TREADY, 1);
    @(posedge ACLK); #1;
    bus.TVALID = 1'b0;
    bus.out_ready = 1'b1;
    cyc(20);
    chk("fill_drained", level, 0);

    // Simultaneous push/pop at level 5
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      push_word(64'h500 + 64'(i), 8'hFF, 3'd0, 1'b1);
    bus.TVALID = 1'b0;
    @(negedge ACLK);
    chk("lvl5_before", level, 5);
    @(posedge ACLK); #1;
    drive(64'h505, 8'h03, 3'd2, 1'b1);
    bus.out_ready = 1'b1;
    @(posedge ACLK); #1;
    bus.TVALID = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge ACLK);
    chk("lvl5_pushpop", level, 5);
    @(posedge ACLK); #1;
    bus.out_ready = 1'b1;
    cyc(8);

    // Reset mid-packet at level 3
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      push_word(64'hBAD0 + 64'(i), 8'hFF, 3'd0, 1'b0);
    bus.TVALID = 1'b0;
    @(negedge ACLK);
    chk("pre_rst_level", level, 3);
    @(posedge ACLK); #1;
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("midrst_valid", bus.out_valid, 0);
    chk("midrst_level", level, 0);
    chk("midrst_busy", rx_busy, 0);
    @(posedge ACLK); #1;
    push_word(64'hC001, 8'hFF, 3'd0, 1'b0);
    push_word(64'hC002, 8'h01, 3'd1, 1'b1);
    bus.TVALID = 1'b0;
    bus.out_ready = 1'b1;
    cyc(5);
    chk("post_rst_drained", level, 0);

    // 3-word packet then 20-word packet, consumer ready
    pop_base = pop_cnt;
    push_word(64'hA1, 8'hFF, 3'd0, 1'b0);
    bus.TVALID = 1'b0;
    @(negedge ACLK);
`ifdef AXIS_RX_STORE_FWD_EN
    chk("sf_withhold", bus.out_valid, 0);
`else
    chk("ct_release", bus.out_valid, 1);
`endif
    @(posedge ACLK); #1;
    push_word(64'hA2, 8'hFF, 3'd0, 1'b0);
    push_word(64'hA3, 8'h07, 3'd3, 1'b1);
    for (int i = 0; i < 20; i++)
      push_word(64'hB00 + 64'(i), 8'hFF, 3'd0, i == 19);
    bus.TVALID = 1'b0;
    cyc(25);
    chk("long_pkt_popped", pop_cnt - pop_base, 23);
    chk("long_pkt_level", level, 0);

    // Randomised traffic with occasional reset
    acc = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!bus.TVALID || acc) begin
        bus.TVALID = ($urandom_range(0, 3) != 0);
        bus.TDATA  = {$urandom, $urandom};
        bus.TKEEP  = 8'($urandom);
        bus.TUSER  = 3'($urandom);
        bus.TLAST  = ($urandom_range(0, 4) == 0);
      end
      bus.out_ready = ((c / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                           : ($urandom_range(0, 3) == 0);
      ARESET = ($urandom_range(0, 499) == 0);
      @(negedge ACLK);
      acc = bus.TVALID && bus.TREADY;
      @(posedge ACLK); #1;
    end
    ARESET = 1'b0;
    bus.TVALID = 1'b0;
    bus.TLAST = 1'b1;
    bus.out_ready = 1'b1;
    cyc(40);
    chk("final_level", level, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_rx_buffer.md
# axis_rx_buffer

Parametrised AXI-Stream slave receiver that accepts a byte-qualified stream and buffers it in a synchronous FIFO. It presents the stream first-word-fall-through on a valid/ready output port, with real backpressure, TLAST/TKEEP/TUSER carried per word, and packet tracking. It sits at the stream ingress of the SHA3 datapath, replacing the single-register receiver, and feeds the absorb/padding logic.

## Interface
Parameters:
- DATA_WIDTH, 64: TDATA width; multiple of 8, ≥ 8.
- DEPTH, 16: FIFO entries; power of two, ≥ 2.
- USER_WIDTH, 3: TUSER width (byte count of last word).

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  synchronous reset, active-high.
- TDATA  in  DATA_WIDTH  stream data.
- TVALID  in  1  source valid.
- TREADY  out  1  receiver ready.
- TLAST  in  1  last word of packet.
- TKEEP  in  DATA_WIDTH/8  byte-valid qualifiers.
- TUSER  in  USER_WIDTH  sideband, stored with word.
- out_data  out  DATA_WIDTH  head-of-FIFO data.
- out_keep  out  DATA_WIDTH/8  head TKEEP.
- out_user  out  USER_WIDTH  head TUSER.
- out_last  out  1  head TLAST.
- out_valid  out  1  head word available.
- out_ready  in  1  consumer takes head word.
- level  out  $clog2(DEPTH)+1  words stored.
- rx_busy  out  1  packet open (words accepted, TLAST not yet seen).

## Operation
- Input FSM: IDLE → WAIT_FIRST → IN_PACKET.
  - IDLE: entered on reset; TREADY=0; leaves unconditionally after 1 cycle.
  - WAIT_FIRST: push of a word with TLAST=0 → IN_PACKET. TLAST=1 (single-word packet) stays.
  - IN_PACKET: push with TLAST=1 → WAIT_FIRST.
  - rx_busy = (state==IN_PACKET).
- Push = TVALID && TREADY. Pop = out_valid && out_ready.
- TREADY = (state≠IDLE) && (level<DEPTH). Computed from registered state; no dependence on out_ready. When full, no push occurs even if a pop happens in the same cycle.
- Each entry stores {TDATA, TKEEP, TUSER, TLAST} unchanged. TKEEP=0 words are stored as-is.
- Pointers: $clog2(DEPTH) bits, natural wrap. level: +1 on push only, −1 on pop only, unchanged on both.
- out_valid = (level≠0) in default mode. out_* hold the head entry; they are don't-care while out_valid=0.

## Timing
- Reset (ARESET high at an edge) clears state→IDLE, pointers, level=0, and the packet counter. Contents are discarded. This applies mid-packet too; the partial packet is lost.
- Output values after reset: TREADY=0, out_valid=0, level=0, rx_busy=0. TREADY=1 from the second edge after reset deassertion.
- Latency: a word pushed at edge N appears on out_* with out_valid=1 after edge N (cycle N+1). No same-cycle bypass.
- Full: TREADY drops in the cycle after the edge where level reaches DEPTH. It rises in the cycle after the first pop.
- Empty: out_valid drops after the edge where the last word pops with no push.
- Source must hold TDATA/TVALID while TREADY=0. The receiver does not check this.

## Configuration
- AXIS_RX_STORE_FWD_EN defined: store-and-forward mode.
  - A packet counter (width $clog2(DEPTH)+1) counts +1 on a push with TLAST and −1 on a pop with TLAST; it is unchanged when both occur in the same cycle.
  - out_valid = (pkt_count≠0) || (level==DEPTH). The full-with-no-complete-packet case releases words cut-through to avoid deadlock on packets longer than DEPTH.
- Undefined: cut-through only; no counter is instantiated; out_valid = (level≠0).

## Structure
- Package axis_rx_pkg holds the state enum (IDLE, WAIT_FIRST, IN_PACKET), a storage-entry struct typedef parametrised by localparam widths, and a ptr-width helper function.
- Sub-module axis_rx_fifo_mem: DEPTH×entry register array with 1 write and 1 async read port. Pointers, level, FSM and flags stay in axis_rx_buffer.

## Test plan
- Reset then idle: TREADY=0 in cycle 1 after reset, 1 from cycle 2. out_valid=0, level=0.
- 4-word packet (TDATA 0x11..0x44, TLAST on 4th), out_ready=1: out_data 0x11..0x44 each 1 cycle after push, out_last on 0x44. rx_busy high from word 1 until the 4th push.
- Fill with out_ready=0: TREADY=0 once level=16. Hold 3 cycles, then one pop → TREADY=1 the next cycle, level 15. Order preserved across pointer wrap.
- Simultaneous push/pop at level 5: level stays 5. Data order intact.
- ARESET pulse mid-packet at level 3: next cycle out_valid=0, level=0, rx_busy=0. The new packet after reset is output cleanly.
- AXIS_RX_STORE_FWD_EN: 3-word packet withholds out_valid until the TLAST push. A 20-word packet with DEPTH=16 is released once level=16 with no loss.
